uart_tx_dev: RTL
================

Name: uart_tx_dev

Overview:
- Bus-attached UART transmitter peripheral; a responder on the Bridge device bus, alongside the timer and seven-segment devices.
- The CPU writes a byte through the Bridge, and the block serialises it on `txd` as 8N1, LSB first.
- On frame completion it raises `IRQ` into one `HardInt` line.
- Register access uses the same `ADD_I`/`WE_I`/`DAT_I`/`DAT_O`/`BE` convention as the timer device.

Parameters:
- CLK_DIV, 5208: reset value of the baud divisor (clock cycles per bit; 50 MHz / 9600).
- DIV_W, 16: width of the divisor register and bit counter.

Ports:
- sys_clk  in  1  single clock; all state changes on its rising edge.
- sys_rst  in  1  reset; synchronous and active-low.
- ADD_I  in  2  register select (`device_addr[3:2]`).
- WE_I  in  1  write strobe from the Bridge; one write per cycle it is high.
- DAT_I  in  32  write data.
- BE  in  4  byte enables for writes.
- DAT_O  out  32  read data; combinational mux on `ADD_I`.
- IRQ  out  1  interrupt request, level.
- txd  out  1  serial output, idle high.

Behaviour:
- Register map (by `ADD_I`):
  - 0 = DATA. Write: `DAT_I[7:0]`, gated by `BE[0]`. Read: last written byte, zero-extended.
  - 1 = CTRL. bit0 EN, bit1 IEN. Write gated by `BE[0]`. Read back zero-extended.
  - 2 = STATUS. bit0 BUSY (read-only), bit1 DONE, bit2 OVR. Read-only except that writing 1 to DONE or OVR clears it (W1C, `BE[0]` gated).
  - 3 = DIV. `DAT_I[DIV_W-1:0]`; `BE[0]` gates the low byte, `BE[1]` gates the high byte.
- Reset (`sys_rst`=0 at a clock edge):
  - `txd`=1, `IRQ`=0.
  - DATA=0, CTRL=0, DONE=0, OVR=0, DIV=CLK_DIV.
  - FSM=IDLE, counters=0.
  - Reset mid-frame aborts the frame immediately; `txd` returns high on that edge.
- Effective divisor: DIV values 0 or 1 are treated as 2.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: `txd`=1, BUSY=0.
  - IDLE -> START: on a DATA write when EN=1. Load the shift register with the byte and clear DONE. `txd` goes 0 on the edge after the write edge.
  - START: `txd`=0 for exactly DIV cycles, then -> DATA with bit index 0.
  - DATA: `txd`=shift[0] for DIV cycles per bit, shift right after each bit. After bit 7 -> STOP.
  - STOP: `txd`=1 for DIV cycles, then -> IDLE. DONE sets on that same edge and BUSY clears on that edge.
- Frame timing: total frame = 10×DIV cycles. BUSY=1 in START, DATA and STOP.
- DATA write while BUSY:
  - DATA register updates (readable).
  - The frame in flight is unaffected.
  - OVR sets; no new frame starts.
- DATA write while EN=0: register updates, no frame, OVR unchanged.
- Clearing EN mid-frame: the current frame completes; EN gates only frame start.
- DIV write while BUSY: ignored, so the bit period is stable within a frame. DIV write while IDLE takes effect for the next frame.
- Simultaneous events:
  - Frame end (DONE set) and a W1C to DONE in the same cycle: set wins, DONE=1.
  - DATA write on the same edge the FSM returns to IDLE: treated as BUSY, so OVR sets and no new frame starts.
- `IRQ` = DONE & IEN, driven from registered state with no extra latency. Clearing IEN drops `IRQ` the next cycle, and DONE is retained.
- Reads have no side effects. `DAT_O` bits above each field read 0.

Test Plan:
- Reset, then read all registers → DATA=0, CTRL=0, STATUS=0, DIV=5208; `txd`=1; `IRQ`=0.
- DIV=4, CTRL=3, write DATA=0xA5 at edge N:
  - `txd`=0 over edges N+1..N+4.
  - Then bits 1,0,1,0,0,1,0,1, 4 cycles each.
  - Then stop bit 1 for 4 cycles.
  - At edge N+40: BUSY=0, DONE=1, `IRQ`=1.
- With DONE=1 and `IRQ`=1, write STATUS=0x2 → DONE=0, `IRQ`=0. A second frame, 0x3C, then serialises correctly.
- Mid-frame DATA write of 0x55 → OVR=1, the `txd` waveform is unchanged from the 0xA5 frame, and no second frame follows.
- CTRL=0, write DATA=0x11 → `txd` stays 1 and BUSY=0. DIV=1 → measured bit period 2 cycles. DIV write mid-frame → bit period unchanged until the next frame.
- Assert `sys_rst`=0 during data bit 3 → on that edge `txd`=1, BUSY=0, DIV=CLK_DIV, and DONE stays 0 after release.

Source files
------------

// File: rtl/uart_tx_dev.sv
// uart_tx_dev: bus-attached 8N1 UART transmitter with DATA/CTRL/STATUS/DIV
// registers and a level interrupt on frame completion.
module uart_tx_dev #(
  parameter int CLK_DIV = 5208,
  parameter int DIV_W   = 16
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [1:0]  ADD_I,
  input  logic        WE_I,
  input  logic [31:0] DAT_I,
  input  logic [3:0]  BE,
  output logic [31:0] DAT_O,
  output logic        IRQ,
  output logic        txd
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             en_q, en_d;
  logic             ien_q, ien_d;
  logic             done_q, done_d;
  logic             ovr_q, ovr_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             txd_q, txd_d;

  logic [DIV_W-1:0] div_eff;
  logic             busy;
  logic             bit_end;
  logic             wr_data;
  logic             wr_ctrl;
  logic             wr_stat;
  logic             wr_div;
  logic             unused_bits;

  assign unused_bits = ^{DAT_I[31:DIV_W], BE[3:2]};

  assign div_eff = (div_q < DIV_W'(2)) ? DIV_W'(2) : div_q;
  assign busy    = (state_q != S_IDLE);
  assign bit_end = (cnt_q == div_eff - DIV_W'(1));

  assign wr_data = WE_I && (ADD_I == 2'd0) && BE[0];
  assign wr_ctrl = WE_I && (ADD_I == 2'd1) && BE[0];
  assign wr_stat = WE_I && (ADD_I == 2'd2) && BE[0];
  assign wr_div  = WE_I && (ADD_I == 2'd3);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    en_d    = en_q;
    ien_d   = ien_q;
    done_d  = done_q;
    ovr_d   = ovr_q;
    div_d   = div_q;

    if (wr_data) data_d = DAT_I[7:0];
    if (wr_ctrl) {ien_d, en_d} = DAT_I[1:0];
    // Divisor is frozen while a frame is on the wire.
    if (wr_div && !busy) begin
      if (BE[0]) div_d[7:0] = DAT_I[7:0];
      if (BE[1]) div_d[DIV_W-1:8] = DAT_I[DIV_W-1:8];
    end
    if (wr_stat && DAT_I[1]) done_d = 1'b0;
    if (wr_stat && DAT_I[2]) ovr_d = 1'b0;
    if (wr_data && busy) ovr_d = 1'b1;

    if (busy) cnt_d = cnt_q + DIV_W'(1);

    unique case (1'b1)
      (state_q == S_IDLE): begin
        if (wr_data && en_q) begin
          state_d = S_START;
          shift_d = DAT_I[7:0];
          cnt_d   = '0;
          done_d  = 1'b0;
        end
      end
      (state_q == S_START): begin
        if (bit_end) begin
          state_d = S_DATA;
          cnt_d   = '0;
          bit_d   = 3'd0;
        end
      end
      (state_q == S_DATA): begin
        if (bit_end) begin
          cnt_d   = '0;
          shift_d = shift_q >> 1;
          if (bit_q == 3'd7) state_d = S_STOP;
          else bit_d = bit_q + 3'd1;
        end
      end
      (state_q == S_STOP): begin
        if (bit_end) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    txd_d = 1'b1;
    if (state_d == S_START) txd_d = 1'b0;
    if (state_d == S_DATA)  txd_d = shift_d[0];
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      en_q    <= 1'b0;
      ien_q   <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
      div_q   <= DIV_W'(CLK_DIV);
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      en_q    <= en_d;
      ien_q   <= ien_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
      div_q   <= div_d;
      txd_q   <= txd_d;
    end
  end

  always_comb begin
    DAT_O = '0;
    unique case (ADD_I)
      2'd0: DAT_O[7:0] = data_q;
      2'd1: DAT_O[1:0] = {ien_q, en_q};
      2'd2: DAT_O[2:0] = {ovr_q, done_q, busy};
      2'd3: DAT_O[DIV_W-1:0] = div_q;
      default: DAT_O = '0;
    endcase
  end

  assign IRQ = done_q & ien_q;
  assign txd = txd_q;

endmodule
